// File: rtl/rom_arbiter.sv
// rom_arbiter: fetch/load port arbiter in front of a 4-byte-wide ROM.
// Macro ROM_ARB_RR_EN selects round-robin; otherwise the load port wins ties.
module rom_arbiter #(
    parameter logic [15:0] ROM_BASE  = 16'h8000,
    parameter int          READ_SIZE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        ls_req,
    input  logic [15:0] ls_addr,
    output logic        if_gnt,
    output logic        ls_gnt,
    output logic        if_rvalid,
    output logic        ls_rvalid,
    output logic        if_err,
    output logic        ls_err,
    output logic [31:0] rdata,
    output logic [15:0] rom_a,
    output logic        rom_re,
    input  logic [7:0]  rom_q0,
    input  logic [7:0]  rom_q1,
    input  logic [7:0]  rom_q2,
    input  logic [7:0]  rom_q3
);

    localparam logic [15:0] ROM_TOP = 16'hFFFF - 16'(READ_SIZE);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        id_q, id_d;
    logic        if_gnt_q, if_gnt_d;
    logic        ls_gnt_q, ls_gnt_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic        ls_rvalid_q, ls_rvalid_d;
    logic        if_err_q, if_err_d;
    logic        ls_err_q, ls_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] rom_a_q, rom_a_d;
    logic        rom_re_q, rom_re_d;

    logic        any_req;
    logic        pick_ls;
    logic        in_range;
    logic [15:0] sel_addr;

    assign any_req = if_req | ls_req;

`ifdef ROM_ARB_RR_EN
    logic last_ls_q, last_ls_d;

    // Tie goes to the port not served last; pointer moves on every grant
    always_comb begin
        pick_ls   = ls_req & (~if_req | ~last_ls_q);
        last_ls_d = last_ls_q;
        if (state_q == IDLE && any_req) begin
            last_ls_d = pick_ls;
        end
    end

    // Pointer resets to "load served last" so fetch wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ls_q <= 1'b1;
        end else begin
            last_ls_q <= last_ls_d;
        end
    end
`else
    // Fixed priority: the load port always wins a tie
    always_comb begin
        pick_ls = ls_req;
    end
`endif

    assign sel_addr = pick_ls ? ls_addr : if_addr;
    assign in_range = (sel_addr >= ROM_BASE) && (sel_addr <= ROM_TOP);

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_err_d    = 1'b0;
        ls_err_d    = 1'b0;
        rdata_d     = rdata_q;
        rom_a_d     = 16'h0;
        rom_re_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    id_d     = pick_ls;
                    if_gnt_d = ~pick_ls;
                    ls_gnt_d = pick_ls;
                    if (in_range) begin
                        state_d  = ACCESS;
                        rom_a_d  = sel_addr;
                        rom_re_d = 1'b1;
                    end else begin
                        state_d     = RESP;
                        if_rvalid_d = ~pick_ls;
                        ls_rvalid_d = pick_ls;
                        if_err_d    = ~pick_ls;
                        ls_err_d    = pick_ls;
                        rdata_d     = 32'h0;
                    end
                end
            end
            ACCESS: begin
                state_d  = WAIT;
                rom_a_d  = rom_a_q;
                rom_re_d = 1'b1;
            end
            WAIT: begin
                state_d     = RESP;
                rdata_d     = {rom_q3, rom_q2, rom_q1, rom_q0};
                if_rvalid_d = ~id_q;
                ls_rvalid_d = id_q;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            id_q        <= 1'b0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            rdata_q     <= 32'h0;
            rom_a_q     <= 16'h0;
            rom_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_err_q    <= if_err_d;
            ls_err_q    <= ls_err_d;
            rdata_q     <= rdata_d;
            rom_a_q     <= rom_a_d;
            rom_re_q    <= rom_re_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_err    = if_err_q;
    assign ls_err    = ls_err_q;
    assign rdata     = rdata_q;
    assign rom_a     = rom_a_q;
    assign rom_re    = rom_re_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: randomized scoreboard bench for rom_arbiter.
// Follows ROM_ARB_RR_EN to pick the expected arbitration policy.
module tb_rom_arbiter;

    localparam logic [15:0] ROM_BASE  = 16'h8000;
    localparam int          READ_SIZE = 3;
`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk, rst;
    logic        if_req, ls_req;
    logic [15:0] if_addr, ls_addr;
    logic        if_gnt, ls_gnt, if_rvalid, ls_rvalid, if_err, ls_err;
    logic [31:0] rdata;
    logic [15:0] rom_a;
    logic        rom_re;
    logic [7:0]  rom_q0, rom_q1, rom_q2, rom_q3;

    logic [7:0]  mem [0:65535];

    assign rom_q0 = rom_re ? mem[rom_a] : 8'hxx;
    assign rom_q1 = rom_re ? mem[rom_a + 16'd1] : 8'hxx;
    assign rom_q2 = rom_re ? mem[rom_a + 16'd2] : 8'hxx;
    assign rom_q3 = rom_re ? mem[rom_a + 16'd3] : 8'hxx;

    rom_arbiter #(.ROM_BASE(ROM_BASE), .READ_SIZE(READ_SIZE)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .ls_req(ls_req), .ls_addr(ls_addr),
        .if_gnt(if_gnt), .ls_gnt(ls_gnt),
        .if_rvalid(if_rvalid), .ls_rvalid(ls_rvalid),
        .if_err(if_err), .ls_err(ls_err),
        .rdata(rdata), .rom_a(rom_a), .rom_re(rom_re),
        .rom_q0(rom_q0), .rom_q1(rom_q1), .rom_q2(rom_q2), .rom_q3(rom_q3)
    );

    typedef struct {
        int cyc;
        bit ls;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          ls;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    gnt_t        gq[$];
    rsp_t        rq[$];
    logic [15:0] ra[int];
    logic [15:0] dq_if[$];
    logic [15:0] dq_ls[$];

    int cyc         = 0;
    int next_sample = 0;
    int rst_chk     = -1;
    int n_chk       = 0;
    int n_fail      = 0;
    bit m_last_ls   = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    function automatic bit addr_ok(logic [15:0] a);
        return int'(a) >= int'(ROM_BASE) && int'(a) <= 65535 - READ_SIZE;
    endfunction

    function automatic logic [31:0] rom_word(logic [15:0] a);
        return {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    endfunction

    function automatic logic [15:0] rand_in_range();
        return 16'(int'(ROM_BASE) + $urandom_range(0, 65535 - READ_SIZE - int'(ROM_BASE)));
    endfunction

    function automatic logic [15:0] pick_addr(bit ls);
        logic [15:0] edges [9];
        edges = '{16'h7FFF, 16'h8000, 16'h8001, 16'hFFFB, 16'hFFFC,
                  16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000};
        if (ls && dq_ls.size() > 0) return dq_ls.pop_front();
        if (!ls && dq_if.size() > 0) return dq_if.pop_front();
        case ($urandom_range(0, 2))
            0: return 16'($urandom);
            1: return rand_in_range();
            default: return edges[$urandom_range(0, 8)];
        endcase
    endfunction

    // Transaction-level model: one access sampled at edge s
    function automatic void expect_access(bit w_ls, logic [15:0] a, int s);
        gnt_t g;
        rsp_t r;
        bit   ok;
        ok     = addr_ok(a);
        g.cyc  = s;
        g.ls   = w_ls;
        gq.push_back(g);
        r.cyc  = ok ? s + 2 : s;
        r.ls   = w_ls;
        r.err  = !ok;
        r.data = ok ? rom_word(a) : 32'h0;
        rq.push_back(r);
        if (ok) begin
            ra[s]     = a;
            ra[s + 1] = a;
        end
        next_sample = s + (ok ? 4 : 2);
        m_last_ls   = w_ls;
    endfunction

    function automatic bit ls_wins_tie();
        return RR ? !m_last_ls : 1'b1;
    endfunction

    task automatic run_burst(int n_if, int n_ls);
        int          s;
        bit          w_ls;
        logic [15:0] a;
        while (cyc + 1 < next_sample) @(negedge clk);
        if (n_if > 0) begin
            if_req  = 1'b1;
            if_addr = pick_addr(1'b0);
        end
        if (n_ls > 0) begin
            ls_req  = 1'b1;
            ls_addr = pick_addr(1'b1);
        end
        while (n_if > 0 || n_ls > 0) begin
            s    = cyc + 1;
            w_ls = (n_ls > 0) && (n_if == 0 || ls_wins_tie());
            a    = w_ls ? ls_addr : if_addr;
            expect_access(w_ls, a, s);
            @(negedge clk);
            if (w_ls) begin
                n_ls--;
                if (n_ls > 0) ls_addr = pick_addr(1'b1);
                else begin
                    ls_req  = 1'b0;
                    ls_addr = 16'($urandom);
                end
            end else begin
                n_if--;
                if (n_if > 0) if_addr = pick_addr(1'b0);
                else begin
                    if_req  = 1'b0;
                    if_addr = 16'($urandom);
                end
            end
            while (cyc + 1 < next_sample) @(negedge clk);
        end
    endtask

    task automatic reset_in_wait();
        int   s;
        gnt_t g;
        while (cyc + 1 < next_sample) @(negedge clk);
        if_req  = 1'b1;
        if_addr = rand_in_range();
        s       = cyc + 1;
        g.cyc   = s;
        g.ls    = 1'b0;
        gq.push_back(g);
        ra[s]     = if_addr;
        ra[s + 1] = if_addr;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        rst_chk = s + 2;
        @(negedge clk);
        rst         = 1'b0;
        next_sample = s + 3;
        m_last_ls   = 1'b1;
    endtask

    // Monitor: every cycle, compare outputs with the scoreboard heads
    always @(negedge clk) begin
        gnt_t g;
        rsp_t r;
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            g = gq.pop_front();
            check("gnt", 64'({if_gnt, ls_gnt}), 64'({!g.ls, g.ls}));
        end else begin
            check("gnt_idle", 64'({if_gnt, ls_gnt}), 64'd0);
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            r = rq.pop_front();
            check("rsp", 64'({if_rvalid, ls_rvalid, if_err, ls_err}),
                  64'({!r.ls, r.ls, !r.ls && r.err, r.ls && r.err}));
            check("rdata", 64'(rdata), 64'(r.data));
        end else begin
            check("rsp_idle", 64'({if_rvalid, ls_rvalid, if_err, ls_err}), 64'd0);
        end
        if (ra.exists(cyc)) begin
            check("rom", 64'({rom_re, rom_a}), 64'({1'b1, ra[cyc]}));
            ra.delete(cyc);
        end else begin
            check("rom_idle", 64'({rom_re, rom_a}), 64'd0);
        end
        if (cyc == rst_chk) begin
            check("reset", 64'({if_gnt, ls_gnt, if_rvalid, ls_rvalid,
                                if_err, ls_err, rom_re, rom_a, rdata}), 64'd0);
        end
    end

    initial begin
        int ni, nl;
        rst     = 1'b1;
        if_req  = 1'b0;
        ls_req  = 1'b0;
        if_addr = 16'h0;
        ls_addr = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h8000] = 8'h11;
        mem[16'h8001] = 8'h22;
        mem[16'h8002] = 8'h33;
        mem[16'h8003] = 8'h44;
        repeat (3) @(negedge clk);
        rst_chk = cyc + 1;
        @(negedge clk);
        rst         = 1'b0;
        next_sample = cyc + 1;

        dq_if.push_back(16'h8000);
        run_burst(1, 0);
        dq_ls.push_back(16'h7FFF);
        dq_ls.push_back(16'hFFFD);
        run_burst(0, 2);
        dq_ls.push_back(16'hFFFC);
        dq_ls.push_back(16'hFFFF);
        dq_ls.push_back(16'h0000);
        run_burst(0, 3);
        for (int i = 0; i < 3; i++) begin
            dq_if.push_back(rand_in_range());
            dq_ls.push_back(rand_in_range());
        end
        run_burst(3, 3);
        @(negedge clk);
        reset_in_wait();
        run_burst(1, 1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                reset_in_wait();
            end else begin
                ni = $urandom_range(0, 3);
                nl = $urandom_range(0, 3);
                if (ni + nl > 0) run_burst(ni, nl);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        while (cyc < next_sample + 3) @(negedge clk);
        check("drain_gnt", 64'(gq.size()), 64'd0);
        check("drain_rsp", 64'(rq.size()), 64'd0);
        check("drain_rom", 64'(ra.num()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ROM_BASE, default 16'h8000, lowest ROM byte address.
REQ-002 Parameter READ_SIZE, default 3, extra bytes per access beyond the base byte; the highest legal address is 16'hFFFF - READ_SIZE.
REQ-003 Port clk  in  1  the single clock; every state change occurs on posedge clk only.
REQ-004 Port rst  in  1  reset, synchronous, active-high.
REQ-005 Ports if_req / ls_req  in  1  fetch port / load port request.
REQ-006 Ports if_addr / ls_addr  in  16  byte address per port.
REQ-007 Ports if_gnt / ls_gnt  out  1  one-cycle pulse when the request is accepted.
REQ-008 Ports if_rvalid / ls_rvalid  out  1  one-cycle response pulse.
REQ-009 Ports if_err / ls_err  out  1  out-of-range flag, valid with rvalid.
REQ-010 Port rdata  out  32  response data, shared by both ports: {q3,q2,q1,q0}, q0 in bits 7:0.
REQ-011 Port rom_a  out  16  ROM address.
REQ-012 Port rom_re  out  1  ROM read enable.
REQ-013 Ports rom_q0..rom_q3  in  8 each  ROM data bytes, high-Z when rom_re=0.

Function
REQ-014 States: IDLE, ACCESS, WAIT, RESP; all outputs are registered.
REQ-015 IDLE: if neither req is high, the block stays in IDLE; otherwise it selects a winner, latches the winner's address and id, and pulses the winner's gnt in the next cycle.
REQ-016 In-range address (ROM_BASE <= addr <= 16'hFFFF - READ_SIZE): IDLE -> ACCESS.
REQ-017 Out-of-range address: IDLE -> RESP with err=1 and rdata=32'h0; rom_re is never asserted.
REQ-018 ACCESS (1 cycle): rom_a = latched address, rom_re=1; next state WAIT.
REQ-019 WAIT (1 cycle): rom_a and rom_re are held.
REQ-020 WAIT: at the closing edge the block captures rom_q0..3 into rdata; next state RESP.
REQ-021 RESP (1 cycle): the winner's rvalid=1; err as determined; rom_re=0; next state IDLE.
REQ-022 Latency, req sampled in IDLE at edge k: gnt high in cycle k+1; rvalid high in cycle k+3 (in-range) or k+1 (out-of-range, with gnt and rvalid in the same cycle).
REQ-023 Only one access is in flight; req is ignored outside IDLE; the requester holds req/addr until gnt.
REQ-024 A request sampled in IDLE is committed; dropping req afterwards does not cancel it.
REQ-025 Back-to-back: a req held through RESP is sampled in the following IDLE cycle; throughput is one access per 4 cycles.
REQ-026 Outside RESP: rvalid=0 and err=0 on both ports; rdata holds its last value.
REQ-027 rom_re=0 in IDLE and RESP; rom_a=16'h0 when rom_re=0.
REQ-028 Address compares are unsigned 16-bit; an address in the last READ_SIZE bytes of memory (e.g. 16'hFFFD) is out of range; no wrap-around reads occur.

Reset
REQ-029 rst high at a posedge forces IDLE and all outputs to 0 (gnt, rvalid, err, rdata, rom_a, rom_re).
REQ-030 rst mid-operation aborts the in-flight access with no rvalid; the round-robin pointer resets to "data last served".
REQ-031 The first request is evaluated at the first posedge with rst low.

Configuration
REQ-032 Macro ROM_ARB_RR_EN, defined: round-robin arbitration; on simultaneous requests the port not served last wins; after reset, fetch wins the first tie.
REQ-033 Macro ROM_ARB_RR_EN, undefined: fixed priority, load port always wins ties; no pointer register exists.
REQ-034 A lone request wins immediately in both modes.

Verification
REQ-035 if_req with if_addr=16'h8000, ROM[0..3]=11,22,33,44 -> if_gnt in cycle k+1, rom_re high for cycles k+1..k+2, if_rvalid in cycle k+3 with rdata=32'h44332211, err=0.
REQ-036 ls_req with ls_addr=16'h7FFF, then 16'hFFFD -> for each request: ls_gnt and ls_rvalid both in cycle k+1, ls_err=1, rdata=0, rom_re stays 0.
REQ-037 ls_addr=16'hFFFC -> in-range read of the last 4 bytes, err=0.
REQ-038 Both reqs held continuously, ROM_ARB_RR_EN defined -> grants alternate if, ls, if, ls, each 4 cycles apart; undefined -> ls granted every time, if starved.
REQ-039 rst asserted in the WAIT cycle -> no rvalid on either port, all outputs 0 next cycle, a fresh request completes normally.
REQ-040 if_req dropped the cycle after sampling -> the access still completes with if_rvalid in cycle k+3.
